// File: rtl/rf_pkg.sv
// Shared types and sizing helpers for the multi-port register file.
package rf_pkg;

    typedef enum logic [0:0] {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_e;

    // Register count including the hardwired x0.
    function automatic int unsigned rf_nregs(input int unsigned depth);
        return 32'd1 << depth;
    endfunction

endpackage

// File: rtl/rf_wr_arb.sv
// Write-port arbiter: finds the highest-indexed write port targeting i_addr.
// Shared by the array update and the read bypass so both resolve collisions alike.
module rf_wr_arb
    import rf_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 5,
    parameter int NWRITE = 1
) (
    input  logic [DEPTH-1:0]        i_addr,
    input  logic [NWRITE-1:0]       i_we,
    input  logic [NWRITE*DEPTH-1:0] i_waddr,
    input  logic [NWRITE*XLEN-1:0]  i_wdata,
    output logic                    o_hit,
    output logic [XLEN-1:0]         o_data
);

    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        // Ascending scan: a later match overrides, so the highest port wins.
        for (int j = 0; j < NWRITE; j++) begin
            if (i_we[j] && (i_waddr[j*DEPTH +: DEPTH] == i_addr) && (i_addr != '0)) begin
                o_hit  = 1'b1;
                o_data = i_wdata[j*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/multiport_rf.sv
// NREAD-read / NWRITE-write register file with x0 hardwired to zero,
// optional same-cycle write-to-read bypass and a post-reset clear sweep.
module multiport_rf
    import rf_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 5,
    parameter int NREAD  = 2,
    parameter int NWRITE = 1,
    parameter int BYPASS = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREAD-1:0]        rs_en,
    input  logic [NREAD*DEPTH-1:0]  rs_addr,
    output logic [NREAD*XLEN-1:0]   rs_data,
    input  logic [NWRITE-1:0]       rd_we,
    input  logic [NWRITE*DEPTH-1:0] rd_addr,
    input  logic [NWRITE*XLEN-1:0]  rd_data,
    output logic                    ready
);

    localparam int              NREGS    = int'(rf_nregs(DEPTH));
    localparam logic [DEPTH-1:0] LAST_IDX = DEPTH'(NREGS - 1);
    localparam logic [DEPTH-1:0] FIRST_IDX = DEPTH'(1);

    rf_state_e                r_state;
    logic [DEPTH-1:0]         r_clr_idx;
    logic                     r_ready;
    logic [NREAD*XLEN-1:0]    r_rs_data;
    logic [XLEN-1:0]          r_ram [1:NREGS-1];

    logic                              w_run;
    logic                              w_clr_step;
    logic [NREGS-1:1]                  w_reg_hit;
    logic [NREGS-1:1][XLEN-1:0]        w_reg_wdata;
    logic [NREGS-1:1]                  w_ram_we;
    logic [NREGS-1:1][XLEN-1:0]        w_ram_wd;
    logic [NREAD-1:0][DEPTH-1:0]       w_rs_addr;
    logic [NREAD-1:0]                  w_byp_hit;
    logic [NREAD-1:0][XLEN-1:0]        w_byp_data;
    logic [NREAD-1:0][XLEN-1:0]        w_ram_rd;
    logic [NREAD-1:0][XLEN-1:0]        w_rs_next;

    assign w_run = (r_state == RF_RUN);
    // Held reset also leaves the state at CLEAR; keep the sweep off the array until release.
    assign w_clr_step = (r_state == RF_CLEAR) && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RF_CLEAR;
            r_clr_idx <= FIRST_IDX;
            r_ready   <= 1'b0;
        end else if (r_state == RF_CLEAR) begin
            r_clr_idx <= r_clr_idx + FIRST_IDX;
            if (r_clr_idx == LAST_IDX) begin
                r_state <= RF_RUN;
                r_ready <= 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi < NREGS; gi++) begin : g_reg
            rf_wr_arb #(
                .XLEN   (XLEN),
                .DEPTH  (DEPTH),
                .NWRITE (NWRITE)
            ) u_reg_arb (
                .i_addr  (DEPTH'(gi)),
                .i_we    (rd_we),
                .i_waddr (rd_addr),
                .i_wdata (rd_data),
                .o_hit   (w_reg_hit[gi]),
                .o_data  (w_reg_wdata[gi])
            );

            assign w_ram_we[gi] = w_clr_step ? (r_clr_idx == DEPTH'(gi))
                                             : (w_run && w_reg_hit[gi]);
            assign w_ram_wd[gi] = w_clr_step ? '0 : w_reg_wdata[gi];
        end
    endgenerate

    // Storage has no reset; the clear sweep above provides known contents.
    always_ff @(posedge clk) begin
        for (int k = 1; k < NREGS; k++) begin
            if (w_ram_we[k]) begin
                r_ram[k] <= w_ram_wd[k];
            end
        end
    end

    generate
        for (gi = 0; gi < NREAD; gi++) begin : g_rd
            assign w_rs_addr[gi] = rs_addr[gi*DEPTH +: DEPTH];

            rf_wr_arb #(
                .XLEN   (XLEN),
                .DEPTH  (DEPTH),
                .NWRITE (NWRITE)
            ) u_byp_arb (
                .i_addr  (w_rs_addr[gi]),
                .i_we    (rd_we),
                .i_waddr (rd_addr),
                .i_wdata (rd_data),
                .o_hit   (w_byp_hit[gi]),
                .o_data  (w_byp_data[gi])
            );

            assign w_ram_rd[gi]  = (w_rs_addr[gi] == '0) ? '0 : r_ram[w_rs_addr[gi]];
            assign w_rs_next[gi] = (w_rs_addr[gi] == '0)              ? '0 :
                                   ((BYPASS != 0) && w_byp_hit[gi])   ? w_byp_data[gi] :
                                                                        w_ram_rd[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rs_data <= '0;
        end else begin
            for (int i = 0; i < NREAD; i++) begin
                if (!w_run) begin
                    r_rs_data[i*XLEN +: XLEN] <= '0;
                end else if (rs_en[i]) begin
                    r_rs_data[i*XLEN +: XLEN] <= w_rs_next[i];
                end
            end
        end
    end

    assign rs_data = r_rs_data;
    assign ready   = r_ready;

endmodule

// File: tb/tb_multiport_rf.sv
// Randomised plus directed bench for multiport_rf, checking a BYPASS=1 and a
// BYPASS=0 instance side by side against one behavioural register model.
module tb_multiport_rf;

    localparam int XLEN   = 32;
    localparam int DEPTH  = 5;
    localparam int NREAD  = 3;
    localparam int NWRITE = 2;
    localparam int NREGS  = 1 << DEPTH;

    logic                    clk;
    logic                    rst_n;
    logic [NREAD-1:0]        rs_en;
    logic [NREAD*DEPTH-1:0]  rs_addr;
    logic [NWRITE-1:0]       rd_we;
    logic [NWRITE*DEPTH-1:0] rd_addr;
    logic [NWRITE*XLEN-1:0]  rd_data;
    logic [NREAD*XLEN-1:0]   rs_b;
    logic [NREAD*XLEN-1:0]   rs_n;
    logic                    ready_b;
    logic                    ready_n;

    int n_checks = 0;
    int n_fail   = 0;
    int n_cyc    = 0;

    // Behavioural model state
    logic [XLEN-1:0] mem   [NREGS];
    logic [XLEN-1:0] exp_b [NREAD];
    logic [XLEN-1:0] exp_n [NREAD];
    bit              ref_ready;
    int              clr_edges;

    multiport_rf #(
        .XLEN(XLEN), .DEPTH(DEPTH), .NREAD(NREAD), .NWRITE(NWRITE), .BYPASS(1)
    ) u_dut_byp (
        .clk(clk), .rst_n(rst_n), .rs_en(rs_en), .rs_addr(rs_addr), .rs_data(rs_b),
        .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data), .ready(ready_b)
    );

    multiport_rf #(
        .XLEN(XLEN), .DEPTH(DEPTH), .NREAD(NREAD), .NWRITE(NWRITE), .BYPASS(0)
    ) u_dut_nob (
        .clk(clk), .rst_n(rst_n), .rs_en(rs_en), .rs_addr(rs_addr), .rs_data(rs_n),
        .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data), .ready(ready_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%08h want=%08h", tag, got, want);
        end
    endtask

    task automatic idle_in();
        rs_en   = '0;
        rs_addr = '0;
        rd_we   = '0;
        rd_addr = '0;
        rd_data = '0;
    endtask

    task automatic set_rd(input int p, input int a);
        rs_en[p] = 1'b1;
        rs_addr[p*DEPTH +: DEPTH] = DEPTH'(a);
    endtask

    task automatic set_wr(input int p, input int a, input logic [XLEN-1:0] d);
        rd_we[p] = 1'b1;
        rd_addr[p*DEPTH +: DEPTH] = DEPTH'(a);
        rd_data[p*XLEN +: XLEN]   = d;
    endtask

    function automatic logic [XLEN-1:0] port_b(input int p);
        return rs_b[p*XLEN +: XLEN];
    endfunction

    function automatic logic [XLEN-1:0] port_n(input int p);
        return rs_n[p*XLEN +: XLEN];
    endfunction

    task automatic model_reset();
        ref_ready = 1'b0;
        clr_edges = 0;
        for (int i = 0; i < NREAD; i++) begin
            exp_b[i] = '0;
            exp_n[i] = '0;
        end
    endtask

    // One clock edge of the architectural behaviour: reads see pre-edge contents.
    task automatic model_step();
        int a;
        int wa;
        if (!ref_ready) begin
            for (int i = 0; i < NREAD; i++) begin
                exp_b[i] = '0;
                exp_n[i] = '0;
            end
            clr_edges++;
            if (clr_edges == NREGS - 1) begin
                ref_ready = 1'b1;
                for (int k = 0; k < NREGS; k++) mem[k] = '0;
            end
        end else begin
            for (int i = 0; i < NREAD; i++) begin
                if (rs_en[i]) begin
                    a = int'(rs_addr[i*DEPTH +: DEPTH]);
                    if (a == 0) begin
                        exp_b[i] = '0;
                        exp_n[i] = '0;
                    end else begin
                        exp_n[i] = mem[a];
                        exp_b[i] = mem[a];
                        for (int j = 0; j < NWRITE; j++) begin
                            if (rd_we[j] && int'(rd_addr[j*DEPTH +: DEPTH]) == a)
                                exp_b[i] = rd_data[j*XLEN +: XLEN];
                        end
                    end
                end
            end
            for (int j = 0; j < NWRITE; j++) begin
                wa = int'(rd_addr[j*DEPTH +: DEPTH]);
                if (rd_we[j] && wa != 0) mem[wa] = rd_data[j*XLEN +: XLEN];
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        n_cyc++;
        $display("cyc=%0d en=%b ra=%h we=%b wa=%h wd=%h rdy=%b rs_b=%h rs_n=%h",
                 n_cyc, rs_en, rs_addr, rd_we, rd_addr, rd_data, ready_b, rs_b, rs_n);
        chk("ready_b", XLEN'(ready_b), XLEN'(ref_ready));
        chk("ready_n", XLEN'(ready_n), XLEN'(ref_ready));
        for (int i = 0; i < NREAD; i++) begin
            chk($sformatf("rs_b%0d", i), port_b(i), exp_b[i]);
            chk($sformatf("rs_n%0d", i), port_n(i), exp_n[i]);
        end
    endtask

    // Assert reset mid-cycle, confirm outputs fall without a clock edge, release at negedge.
    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_ready_b", XLEN'(ready_b), '0);
        chk("rst_ready_n", XLEN'(ready_n), '0);
        for (int i = 0; i < NREAD; i++) begin
            chk($sformatf("rst_rs_b%0d", i), port_b(i), '0);
            chk($sformatf("rst_rs_n%0d", i), port_n(i), '0);
        end
        model_reset();
        idle_in();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_clear(input string tag);
        for (int k = 1; k < NREGS; k++) begin
            idle_in();
            if (k >= 3 && k < 8) set_wr(0, 5, 32'h0000_00AA);
            tick();
            chk(tag, XLEN'(ready_b), XLEN'(k == NREGS - 1));
        end
        idle_in();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_in();
        model_reset();
        for (int k = 0; k < NREGS; k++) mem[k] = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Clear sequence with writes attempted during it
        run_clear("clr_len");
        for (int a = 1; a < NREGS; a += NREAD) begin
            idle_in();
            for (int p = 0; p < NREAD; p++) set_rd(p, (a + p) % NREGS);
            tick();
        end
        idle_in(); set_rd(0, 5); tick();
        chk("x5_after_clr", port_b(0), '0);

        // Write/read latency with and without bypass
        idle_in(); set_wr(0, 7, 32'hDEAD_BEEF); set_rd(0, 7); tick();
        chk("lat_nob_n1", port_n(0), '0);
        chk("lat_byp_n1", port_b(0), 32'hDEAD_BEEF);
        idle_in(); set_rd(0, 7); tick();
        chk("lat_nob_n2", port_n(0), 32'hDEAD_BEEF);

        // x0 protection
        idle_in();
        set_wr(0, 0, 32'hFFFF_FFFF); set_wr(1, 0, 32'hFFFF_FFFF);
        for (int p = 0; p < NREAD; p++) set_rd(p, 0);
        tick();
        for (int p = 0; p < NREAD; p++) chk($sformatf("x0_b%0d", p), port_b(p), '0);
        idle_in(); set_rd(1, 0); tick();
        chk("x0_later", port_b(1), '0);

        // Write collision: highest port wins
        idle_in(); set_wr(0, 3, 32'h11); set_wr(1, 3, 32'h22); set_rd(0, 3); tick();
        chk("coll_byp", port_b(0), 32'h22);
        chk("coll_nob", port_n(0), '0);
        idle_in(); set_rd(0, 3); tick();
        chk("coll_b", port_b(0), 32'h22);
        chk("coll_n", port_n(0), 32'h22);

        // Read-enable hold
        idle_in(); set_wr(0, 4, 32'h55); tick();
        idle_in(); set_rd(0, 4); tick();
        chk("hold_rd", port_n(0), 32'h55);
        idle_in(); set_wr(0, 4, 32'h66); rs_addr[DEPTH-1:0] = DEPTH'(9); tick();
        chk("hold_b", port_b(0), 32'h55);
        chk("hold_n", port_n(0), 32'h55);
        idle_in(); set_rd(0, 4); tick();
        chk("hold_reen", port_n(0), 32'h66);

        // Reset in RUN, then mid-clear, then full clear again
        idle_in(); set_wr(1, 9, 32'h99); tick();
        idle_in(); set_rd(2, 9); tick();
        chk("x9_pre", port_b(2), 32'h99);
        do_reset();
        for (int k = 0; k < 10; k++) tick();
        do_reset();
        run_clear("clr_len2");
        idle_in(); set_rd(2, 9); tick();
        chk("x9_post", port_b(2), '0);

        // Randomised traffic, addresses biased low to provoke collisions
        for (int c = 0; c < 400; c++) begin
            idle_in();
            for (int p = 0; p < NREAD; p++) begin
                rs_en[p] = 1'($urandom_range(0, 1));
                rs_addr[p*DEPTH +: DEPTH] = DEPTH'(($urandom_range(0, 3) == 0) ?
                                            $urandom_range(0, NREGS - 1) : $urandom_range(0, 7));
            end
            for (int j = 0; j < NWRITE; j++) begin
                rd_we[j] = 1'($urandom_range(0, 1));
                rd_addr[j*DEPTH +: DEPTH] = DEPTH'(($urandom_range(0, 3) == 0) ?
                                            $urandom_range(0, NREGS - 1) : $urandom_range(0, 7));
                rd_data[j*XLEN +: XLEN] = XLEN'($urandom);
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
